// File: rtl/nvdla_glb_done_intr_fmt.sv
// Done-interrupt formatter: queues per-group completion pulses in pending counters
// and emits at most one one-hot done pulse per cycle, round-robin between the groups.
module nvdla_glb_done_intr_fmt #(
  parameter int CNT_W = 3
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [1:0]       done_evt,
  input  logic             flush,
  output logic [1:0]       intr_pd,
  output logic [CNT_W-1:0] pend0_cnt,
  output logic [CNT_W-1:0] pend1_cnt,
  output logic [1:0]       ovf,
  output logic             idle
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       ovf_q, ovf_d;
  logic [1:0]       intr_pd_q, intr_pd_d;
  logic             last_grp_q, last_grp_d;
  logic [1:0]       elig;
  logic [1:0]       grant;

  // A fresh event makes its group eligible the same cycle, bypassing the counter.
  always_comb begin
    elig[0] = (cnt_q[0] != '0) | done_evt[0];
    elig[1] = (cnt_q[1] != '0) | done_evt[1];
    if (elig == 2'b11) begin
      grant = last_grp_q ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      cnt_d[g] = cnt_q[g];
      ovf_d[g] = ovf_q[g];
      if (done_evt[g] && !grant[g]) begin
        if (cnt_q[g] == CNT_MAX) begin
          ovf_d[g] = 1'b1;
        end else begin
          cnt_d[g] = cnt_q[g] + CNT_ONE;
        end
      end else if (!done_evt[g] && grant[g]) begin
        cnt_d[g] = cnt_q[g] - CNT_ONE;
      end
    end
    intr_pd_d  = grant;
    last_grp_d = (grant != 2'b00) ? grant[1] : last_grp_q;
    // Soft clear wins over any event or grant in the same cycle.
    if (flush) begin
      cnt_d[0]   = '0;
      cnt_d[1]   = '0;
      ovf_d      = 2'b00;
      intr_pd_d  = 2'b00;
      last_grp_d = 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      ovf_q      <= 2'b00;
      intr_pd_q  <= 2'b00;
      last_grp_q <= 1'b1;
    end else begin
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      ovf_q      <= ovf_d;
      intr_pd_q  <= intr_pd_d;
      last_grp_q <= last_grp_d;
    end
  end

  assign intr_pd   = intr_pd_q;
  assign pend0_cnt = cnt_q[0];
  assign pend1_cnt = cnt_q[1];
  assign ovf       = ovf_q;
  assign idle      = (cnt_q[0] == '0) && (cnt_q[1] == '0) && (intr_pd_q == 2'b00);

endmodule
